// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and helpers for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

   localparam int MD_XLEN = 32;

   localparam logic [2:0] MDOp_MUL    = 3'd0;
   localparam logic [2:0] MDOp_MULH   = 3'd1;
   localparam logic [2:0] MDOp_MULHSU = 3'd2;
   localparam logic [2:0] MDOp_MULHU  = 3'd3;
   localparam logic [2:0] MDOp_DIV    = 3'd4;
   localparam logic [2:0] MDOp_DIVU   = 3'd5;
   localparam logic [2:0] MDOp_REM    = 3'd6;
   localparam logic [2:0] MDOp_REMU   = 3'd7;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_CALC,
      MD_FIN
   } md_state_e;

   function automatic logic a_is_signed(input logic [2:0] op);
      return (op == MDOp_MULH) || (op == MDOp_MULHSU) || (op == MDOp_DIV) || (op == MDOp_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] op);
      return (op == MDOp_MULH) || (op == MDOp_DIV) || (op == MDOp_REM);
   endfunction

   function automatic logic [MD_XLEN-1:0] negate_if(input logic neg, input logic [MD_XLEN-1:0] v);
      return neg ? (~v + {{(MD_XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit_iter.sv
// One radix-2 step: shift-add for multiply, trial-subtract for restoring divide.
module md_iter
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] acc_next
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      shifted  = acc[2*XLEN-1:XLEN-1];
      diff     = shifted - {1'b0, operand};
      acc_next = {sum, acc[XLEN-1:1]};
      if (is_div) begin
         if (shifted >= {1'b0, operand})
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 CALC cycles plus a FIN cycle,
// with a fast path for divide-by-zero and signed overflow.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      MDOp,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] C
);

   md_state_e         state;
   logic [2:0]        op_q;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_next;
   logic [XLEN-1:0]   operand;
   logic              neg_res;
   logic              neg_rem;
   logic [5:0]        count;

   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              div_zero;
   logic              div_ovf;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   result;

   always_comb begin
      a_neg    = a_is_signed(MDOp) & A[XLEN-1];
      b_neg    = b_is_signed(MDOp) & B[XLEN-1];
      abs_a    = negate_if(a_neg, A);
      abs_b    = negate_if(b_neg, B);
      div_zero = MDOp[2] && (B == '0);
      div_ovf  = ((MDOp == MDOp_DIV) || (MDOp == MDOp_REM)) &&
                 (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
   end

   md_iter #(.XLEN(XLEN)) u_iter (
      .is_div  (op_q[2]),
      .acc     (acc),
      .operand (operand),
      .acc_next(acc_next)
   );

   // Sign correction and output selection for the FIN cycle.
   always_comb begin
      product = neg_res ? (~acc + 64'd1) : acc;
      result  = product[XLEN-1:0];
      case (op_q)
         MDOp_MUL:                           result = product[XLEN-1:0];
         MDOp_MULH, MDOp_MULHSU, MDOp_MULHU: result = product[2*XLEN-1:XLEN];
         MDOp_DIV, MDOp_DIVU:                result = negate_if(neg_res, acc[XLEN-1:0]);
         MDOp_REM, MDOp_REMU:                result = negate_if(neg_rem, acc[2*XLEN-1:XLEN]);
         default:                            result = product[XLEN-1:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= MD_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         C       <= '0;
         count   <= '0;
         op_q    <= '0;
         acc     <= '0;
         operand <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               MD_IDLE: begin
                  if (start) begin
                     op_q <= MDOp;
                     busy <= 1'b1;
                     if (div_zero || div_ovf) begin
                        // Special results are preloaded as {remainder, quotient} with no sign fixup.
                        acc     <= div_zero ? {A, {XLEN{1'b1}}} : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                        operand <= '0;
                        neg_res <= 1'b0;
                        neg_rem <= 1'b0;
                        state   <= MD_FIN;
                     end else begin
                        acc     <= MDOp[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                        operand <= MDOp[2] ? abs_b : abs_a;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        count   <= 6'd32;
                        state   <= MD_CALC;
                     end
                  end
               end
               MD_CALC: begin
                  acc   <= acc_next;
                  count <= count - 6'd1;
                  if (count == 6'd1)
                     state <= MD_FIN;
               end
               MD_FIN: begin
                  C     <= result;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= MD_IDLE;
               end
               default: begin
                  state <= MD_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit implementing the RV32M operations for the pipelined processor. It sits in EX beside the single-cycle ALU. It accepts one operation per start pulse and holds the pipeline through `busy`. It returns a 32-bit result with a one-cycle `done` pulse. Operands arrive in the same signed-32-bit form the ALU receives; the result feeds the same EX/MEM write-back path as the ALU result `C`.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. Sampled only in IDLE; ignored otherwise.
- `flush` input 1: pipeline kill. Aborts any operation in progress.
- `MDOp` input 3: RV32M funct3 code. 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- `A` input 32: rs1 operand. Signed or unsigned per MDOp.
- `B` input 32: rs2 operand.
- `busy` output 1: high from the cycle after an accepted start through the FIN cycle. Hazard unit stalls IF/ID/EX while high.
- `done` output 1: one-cycle pulse; `C` is valid in that cycle.
- `C` output 32: result. Held until the next `done`.

## Operation
- States: IDLE, CALC, FIN.
- IDLE → CALC on `start`. Latch `MDOp`; latch `|A|`, `|B|` per signedness rules; latch result sign and a 6-bit counter set to 32.
- Signedness rules:
  - mulh: both operands signed.
  - mulhsu: A signed, B unsigned.
  - mulhu, divu, remu: both unsigned.
  - div, rem: both signed.
  - mul: sign is irrelevant.
- IDLE → FIN directly (fast path, no CALC) on these special cases:
  - Divide by zero (B==0): quotient = 32'hFFFF_FFFF; remainder = A.
  - Signed overflow (div/rem with A=32'h8000_0000, B=32'hFFFF_FFFF): quotient = 32'h8000_0000; remainder = 0.
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator, one bit per cycle.
- CALC, divide: radix-2 restoring division, giving a 32-bit quotient and remainder, one bit per cycle.
- The counter decrements each CALC cycle; CALC → FIN when the counter reaches 1.
- FIN:
  - Apply sign correction with two's-complement negation: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Select the output: low 32 bits for mul, high 32 bits for mulh/mulhsu/mulhu, quotient for div/divu, remainder for rem/remu.
  - Register the selection into `C`, pulse `done`, and return to IDLE.
- `flush` in any state returns to IDLE on the next edge. No `done` is produced and `C` is unchanged. `flush` and `start` in the same IDLE cycle: `flush` wins and the request is dropped.
- All arithmetic is modulo 2^32/2^64. No exceptions are raised.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `C`=0, counter 0.
- Normal path: start sampled at edge k. `busy`=1 during cycles k+1…k+33. `done`=1 and `C` valid in cycle k+34. `busy`=0 in that cycle.
- Fast path: start at edge k. `busy`=1 in cycle k+1. `done` in cycle k+2.
- Earliest next start is in the `done` cycle, so back-to-back operations are allowed.
- Reset asserted mid-operation forces the reset values immediately (asynchronously).
- `A`, `B`, `MDOp` need only be stable in the start cycle.

## Structure
- Add `MDOp_*` defines (3-bit codes above) to `ctrl_encode_def.v`, alongside the ALUOp codes. Also add state encodings `MD_IDLE`, `MD_CALC`, `MD_FIN`.
- One natural sub-module, `md_iter`: the combinational single-step datapath (one add-shift or one trial-subtract step). The FSM/registers stay in `muldiv_unit`.

## Test plan
- mul: A=7, B=-3 → `C`=32'hFFFF_FFEB. `done` exactly 34 cycles after start; `busy` high 33 cycles.
- mulh / mulhu: A=B=32'h8000_0000. mulh → 32'h4000_0000. mulhu → 32'h4000_0000. mulhsu A=-1, B=2 → 32'hFFFF_FFFF.
- div/rem: A=-7, B=2 → div -3 (32'hFFFF_FFFD), rem -1. divu A=32'hFFFF_FFFF, B=16 → 32'h0FFF_FFFF. remu → 15.
- Special cases: div A=5, B=0 → 32'hFFFF_FFFF; rem → 5. div A=32'h8000_0000, B=-1 → 32'h8000_0000; rem → 0. All with `done` 2 cycles after start.
- `flush` at cycle 10 of a div → no `done`; `busy`=0 the next cycle; `C` keeps its prior value. `start` while busy is ignored.
- `rst` pulse mid-CALC → `busy`, `done`, `C` read 0 immediately. A following mul 3×4 → 12 with normal latency.
